// File: rtl/mem_access_stage.sv
// MEM stage: turns EX/MEM load/store controls into a req/ack memory transaction and registers MEM/WB.
// Latency is 1 cycle for non-memory ops. Memory ops cost one IDLE stall cycle plus the ACCESS cycles up to and including the ack; stall_o freezes upstream until then.
module mem_access_stage #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic [4:0]  RDaddr_i,
   input  logic [31:0] RS2data_i,
   input  logic [31:0] ALUResult_i,
   input  logic        MemRead_i,
   input  logic        MemWrite_i,
   input  logic        RegWrite_i,
   input  logic        MemtoReg_i,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_ack_i,
   input  logic [31:0] mem_rdata_i,
   output logic        stall_o,
   output logic        err_o,
   output logic [4:0]  RDaddr_o,
   output logic        RegWrite_o,
   output logic        MemtoReg_o,
   output logic [31:0] ALUResult_o,
   output logic [31:0] MemData_o
);

   typedef enum logic [1:0] {IDLE, ACCESS, ERR} state_t;

   localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

   state_t     state;
   logic [7:0] waitCnt;
   logic       access;
   logic       ackLoad;

   assign access      = start_i & (MemRead_i | MemWrite_i);
   assign mem_req_o   = (state == ACCESS);
   assign mem_we_o    = mem_req_o & MemWrite_i;
   assign mem_addr_o  = {ALUResult_i[31:2], 2'b00};
   assign mem_wdata_o = RS2data_i;
   assign err_o       = (state == ERR);
   // A simultaneous read+write is a store, so only a pure read captures data.
   assign ackLoad     = mem_req_o & mem_ack_i & ~MemWrite_i;

   always_comb begin
      stall_o = 1'b0;
      case (state)
         IDLE:    stall_o = access;
         ACCESS:  stall_o = ~mem_ack_i;
         default: stall_o = 1'b1;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state   <= IDLE;
         waitCnt <= 8'd0;
      end else begin
         case (state)
            IDLE: begin
               if (access) begin
                  state   <= ACCESS;
                  waitCnt <= 8'd0;
               end
            end
            ACCESS: begin
               if (mem_ack_i) begin
                  state <= IDLE;
               end else if (waitCnt == LAST_WAIT) begin
                  state <= ERR;
               end else begin
                  waitCnt <= waitCnt + 8'd1;
               end
            end
            default: state <= ERR;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         RDaddr_o    <= 5'd0;
         RegWrite_o  <= 1'b0;
         MemtoReg_o  <= 1'b0;
         ALUResult_o <= 32'd0;
         MemData_o   <= 32'd0;
      end else begin
         if (stall_o || !start_i) begin
            RegWrite_o <= 1'b0;
            MemtoReg_o <= 1'b0;
         end else begin
            RDaddr_o    <= RDaddr_i;
            RegWrite_o  <= RegWrite_i;
            MemtoReg_o  <= MemtoReg_i;
            ALUResult_o <= ALUResult_i;
         end
         if (ackLoad) begin
            MemData_o <= mem_rdata_i;
         end
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: the bench acts as the data memory and compares MEM/WB results as they are produced.
module tb_mem_access_stage;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        start_i;
   logic [4:0]  RDaddr_i;
   logic [31:0] RS2data_i;
   logic [31:0] ALUResult_i;
   logic        MemRead_i;
   logic        MemWrite_i;
   logic        RegWrite_i;
   logic        MemtoReg_i;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic        mem_ack_i;
   logic [31:0] mem_rdata_i;
   logic        stall_o;
   logic        err_o;
   logic [4:0]  RDaddr_o;
   logic        RegWrite_o;
   logic        MemtoReg_o;
   logic [31:0] ALUResult_o;
   logic [31:0] MemData_o;

   mem_access_stage #(.TIMEOUT(4)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
      .RDaddr_i(RDaddr_i), .RS2data_i(RS2data_i), .ALUResult_i(ALUResult_i),
      .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i), .RegWrite_i(RegWrite_i),
      .MemtoReg_i(MemtoReg_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i),
      .mem_rdata_i(mem_rdata_i), .stall_o(stall_o), .err_o(err_o),
      .RDaddr_o(RDaddr_o), .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o),
      .ALUResult_o(ALUResult_o), .MemData_o(MemData_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [4:0]  rd;
      logic        rw;
      logic        m2r;
      logic [31:0] alu;
      logic [31:0] md;
   } memwb_t;

   memwb_t      expQ[$];
   logic [31:0] expMemData;
   int          checks = 0;
   int          errors = 0;

   task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   task automatic setInstr(input logic [4:0] rd, input logic [31:0] rs2, input logic [31:0] alu,
                           input logic mr, input logic mw, input logic rw, input logic m2r);
      RDaddr_i    = rd;
      RS2data_i   = rs2;
      ALUResult_i = alu;
      MemRead_i   = mr;
      MemWrite_i  = mw;
      RegWrite_i  = rw;
      MemtoReg_i  = m2r;
   endtask

   // Issue one instruction, answer its memory request on ACCESS cycle ackCycle, then check MEM/WB.
   task automatic doInstr(input string name, input logic [4:0] rd, input logic [31:0] rs2,
                          input logic [31:0] alu, input logic mr, input logic mw,
                          input logic rw, input logic m2r, input int ackCycle,
                          input logic [31:0] rdata);
      logic        isMem;
      logic        doneNow;
      int          stalls;
      int          acc;
      memwb_t      got;
      memwb_t      want;
      logic [31:0] wordAddr;
      isMem    = mr | mw;
      wordAddr = {alu[31:2], 2'b00};
      setInstr(rd, rs2, alu, mr, mw, rw, m2r);
      start_i = 1'b1;
      if (mr && !mw) expMemData = rdata;
      expQ.push_back('{rd, rw, m2r, alu, expMemData});
      stalls  = 0;
      acc     = 0;
      doneNow = 1'b0;
      for (int c = 0; c < 40 && !doneNow; c++) begin
         mem_ack_i   = 1'b0;
         mem_rdata_i = 32'hBAD0_0000 + 32'(c);
         if (mem_req_o) begin
            acc++;
            if (acc == 1) begin
               checkVal({name, "_addr"}, mem_addr_o, wordAddr);
               checkVal({name, "_we"}, {31'd0, mem_we_o}, {31'd0, mw});
               if (mw) checkVal({name, "_wdata"}, mem_wdata_o, rs2);
            end
            if (mw) checkVal({name, "_regwr_during"}, {31'd0, RegWrite_o}, 32'd0);
            if (acc == ackCycle) begin
               mem_ack_i   = 1'b1;
               mem_rdata_i = rdata;
            end
         end
         #1;
         if (stall_o) stalls++;
         doneNow = !isMem || mem_ack_i;
         tick();
         mem_ack_i = 1'b0;
      end
      if (!doneNow) checkVal({name, "_ack_budget"}, 32'd0, 32'd1);
      checkVal({name, "_stalls"}, 32'(stalls), isMem ? 32'(ackCycle) : 32'd0);
      checkVal({name, "_req_after"}, {31'd0, mem_req_o}, 32'd0);
      want = expQ.pop_front();
      got  = '{RDaddr_o, RegWrite_o, MemtoReg_o, ALUResult_o, MemData_o};
      checkVal({name, "_rd"}, {27'd0, got.rd}, {27'd0, want.rd});
      checkVal({name, "_rw"}, {31'd0, got.rw}, {31'd0, want.rw});
      checkVal({name, "_m2r"}, {31'd0, got.m2r}, {31'd0, want.m2r});
      checkVal({name, "_alu"}, got.alu, want.alu);
      checkVal({name, "_md"}, got.md, want.md);
   endtask

   initial begin
      int acc;
      rst_i       = 1'b1;
      start_i     = 1'b0;
      mem_ack_i   = 1'b0;
      mem_rdata_i = 32'd0;
      expMemData  = 32'd0;
      setInstr(5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      rst_i = 1'b0;
      #1;
      checkVal("rst_req", {31'd0, mem_req_o}, 32'd0);
      checkVal("rst_err", {31'd0, err_o}, 32'd0);
      checkVal("rst_stall", {31'd0, stall_o}, 32'd0);
      checkVal("rst_rw", {31'd0, RegWrite_o}, 32'd0);
      checkVal("rst_alu", ALUResult_o, 32'd0);
      checkVal("rst_md", MemData_o, 32'd0);
      @(negedge clk_i);

      doInstr("alu",   5'd5, 32'd0,         32'h0000_0010, 1'b0, 1'b0, 1'b1, 1'b0, 0, 32'd0);
      doInstr("load",  5'd7, 32'd0,         32'h0000_0104, 1'b1, 1'b0, 1'b1, 1'b1, 4, 32'hDEAD_BEEF);
      doInstr("store", 5'd9, 32'h1234_5678, 32'h0000_0022, 1'b0, 1'b1, 1'b0, 1'b0, 2, 32'h0BAD_0BAD);
      doInstr("rdwr",  5'd3, 32'hCAFE_F00D, 32'h0000_0043, 1'b1, 1'b1, 1'b0, 1'b0, 1, 32'h0000_0055);
      doInstr("ld1",   5'd1, 32'd0,         32'h0000_0200, 1'b1, 1'b0, 1'b1, 1'b1, 1, 32'h1111_1111);
      doInstr("ld2",   5'd2, 32'd0,         32'h0000_0204, 1'b1, 1'b0, 1'b1, 1'b1, 1, 32'h2222_2222);
      checkVal("queue_empty", 32'(expQ.size()), 32'd0);

      // Pipeline disabled: an ALU op becomes a bubble and the data fields hold.
      setInstr(5'd12, 32'd0, 32'h0000_0999, 1'b0, 1'b0, 1'b1, 1'b1);
      start_i = 1'b0;
      tick();
      checkVal("bub_rw", {31'd0, RegWrite_o}, 32'd0);
      checkVal("bub_m2r", {31'd0, MemtoReg_o}, 32'd0);
      checkVal("bub_rd", {27'd0, RDaddr_o}, 32'd2);
      checkVal("bub_alu", ALUResult_o, 32'h0000_0204);

      // Unanswered load: TIMEOUT=4 ACCESS cycles then ERR.
      setInstr(5'd4, 32'd0, 32'h0000_0300, 1'b1, 1'b0, 1'b1, 1'b1);
      start_i = 1'b1;
      acc = 0;
      for (int c = 0; c < 40 && !err_o; c++) begin
         if (mem_req_o) acc++;
         tick();
      end
      checkVal("to_cycles", 32'(acc), 32'd4);
      #1;
      checkVal("to_err", {31'd0, err_o}, 32'd1);
      checkVal("to_stall", {31'd0, stall_o}, 32'd1);
      checkVal("to_req", {31'd0, mem_req_o}, 32'd0);
      mem_ack_i   = 1'b1;
      mem_rdata_i = 32'h7777_7777;
      tick();
      mem_ack_i = 1'b0;
      tick();
      checkVal("to_hold_err", {31'd0, err_o}, 32'd1);
      checkVal("to_late_md", MemData_o, 32'h2222_2222);
      checkVal("to_rw", {31'd0, RegWrite_o}, 32'd0);
      start_i = 1'b0;
      rst_i   = 1'b1;
      tick();
      rst_i = 1'b0;
      #1;
      checkVal("rec_err", {31'd0, err_o}, 32'd0);
      checkVal("rec_stall", {31'd0, stall_o}, 32'd0);
      checkVal("rec_rd", {27'd0, RDaddr_o}, 32'd0);
      checkVal("rec_alu", ALUResult_o, 32'd0);
      checkVal("rec_md", MemData_o, 32'd0);
      @(negedge clk_i);

      // Reset in the middle of an access; the following ack must be ignored.
      start_i = 1'b1;
      tick();
      checkVal("ra_req", {31'd0, mem_req_o}, 32'd1);
      rst_i = 1'b1;
      tick();
      rst_i       = 1'b0;
      start_i     = 1'b0;
      mem_ack_i   = 1'b1;
      mem_rdata_i = 32'h9999_9999;
      #1;
      checkVal("ra_req_rst", {31'd0, mem_req_o}, 32'd0);
      tick();
      mem_ack_i = 1'b0;
      checkVal("ra_md", MemData_o, 32'd0);
      checkVal("ra_rw", {31'd0, RegWrite_o}, 32'd0);
      checkVal("ra_err", {31'd0, err_o}, 32'd0);
      checkVal("ra_req_after", {31'd0, mem_req_o}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
